// File: rtl/buffer_owner_sequencer.sv
// Arbitrates the shared Zorro data/address buffers between host slave cycles and NCR
// bus-master tenures, sequencing direction before enable and enable-off before release.
module buffer_owner_sequencer #(
  parameter int SETUP_CYCLES = 1,
  parameter int TURN_CYCLES  = 1,
  parameter int MAX_MST_CYC  = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic SLV_REQ,
  input  logic SLV_READ,
  input  logic SLV_DONE,
  input  logic MST_REQ,
  input  logic MST_READ,
  input  logic MST_DONE,
  output logic SLV_GNT,
  output logic MST_GNT,
  output logic MST_PREEMPT,
  output logic DBOE_n,
  output logic ABOE_n,
  output logic MAOE_n,
  output logic D2Z_n,
  output logic Z2D_n,
  output logic BUSY
);

  // state | meaning
  // IDLE  | buffers released, all enables off
  // S_SET | slave direction/address enable set up, data path off
  // S_ON  | slave owns buffers, data path on
  // M_SET | master direction/address enable set up, data path off
  // M_ON  | master owns buffers, data path on, tenure counting
  // TURN  | data path off, direction held for turnaround gap
  typedef enum logic [2:0] {IDLE, S_SET, S_ON, M_SET, M_ON, TURN} state_t;

  localparam int PHASE_MAX = (SETUP_CYCLES > TURN_CYCLES) ? SETUP_CYCLES : TURN_CYCLES;
  localparam int PW        = $clog2(PHASE_MAX) + 1;
  localparam int TW        = $clog2(MAX_MST_CYC + 1);

  localparam logic [PW-1:0] SETUP_LOAD = PW'(SETUP_CYCLES - 1);
  localparam logic [PW-1:0] TURN_LOAD  = PW'(TURN_CYCLES - 1);
  localparam logic [TW-1:0] TEN_MAX    = TW'(MAX_MST_CYC);

  state_t        state;
  logic          last_mst;
  logic          cur_mst;
  logic          dir_d2z;
  logic [PW-1:0] phase_cnt;
  logic [TW-1:0] tenure_cnt;
  logic          pick_slv;
  logic          active;

  // Round robin only matters when both request; the loser waits for the next IDLE.
  assign pick_slv = SLV_REQ && (!MST_REQ || last_mst);
  assign active   = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      last_mst    <= 1'b1;
      cur_mst     <= 1'b0;
      dir_d2z     <= 1'b0;
      phase_cnt   <= '0;
      tenure_cnt  <= '0;
      SLV_GNT     <= 1'b0;
      MST_GNT     <= 1'b0;
      MST_PREEMPT <= 1'b0;
      DBOE_n      <= 1'b1;
      ABOE_n      <= 1'b1;
      MAOE_n      <= 1'b1;
      D2Z_n       <= 1'b1;
      Z2D_n       <= 1'b1;
      BUSY        <= 1'b0;
    end else begin
      SLV_GNT     <= (state == S_ON);
      MST_GNT     <= (state == M_ON);
      MST_PREEMPT <= (state == M_ON) && (tenure_cnt == TEN_MAX) && SLV_REQ;
      DBOE_n      <= !((state == S_ON) || (state == M_ON));
      ABOE_n      <= !(active && !cur_mst);
      MAOE_n      <= !(active && cur_mst);
      D2Z_n       <= !(active && dir_d2z);
      Z2D_n       <= !(active && !dir_d2z);
      BUSY        <= active;

      case (state)
        IDLE: begin
          if (pick_slv) begin
            state     <= S_SET;
            cur_mst   <= 1'b0;
            dir_d2z   <= SLV_READ;
            phase_cnt <= SETUP_LOAD;
          end else if (MST_REQ) begin
            state     <= M_SET;
            cur_mst   <= 1'b1;
            dir_d2z   <= !MST_READ;
            phase_cnt <= SETUP_LOAD;
          end
        end
        S_SET: begin
          if (!SLV_REQ) begin
            state     <= TURN;
            phase_cnt <= TURN_LOAD;
          end else if (phase_cnt == '0) begin
            state <= S_ON;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        M_SET: begin
          if (!MST_REQ) begin
            state     <= TURN;
            phase_cnt <= TURN_LOAD;
          end else if (phase_cnt == '0) begin
            state      <= M_ON;
            tenure_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        S_ON: begin
          if (SLV_DONE) begin
            state     <= TURN;
            last_mst  <= 1'b0;
            phase_cnt <= TURN_LOAD;
          end
        end
        M_ON: begin
          if (tenure_cnt != TEN_MAX)
            tenure_cnt <= tenure_cnt + 1'b1;
          if (MST_DONE) begin
            state     <= TURN;
            last_mst  <= 1'b1;
            phase_cnt <= TURN_LOAD;
          end
        end
        TURN: begin
          if (phase_cnt == '0)
            state <= IDLE;
          else
            phase_cnt <= phase_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_owner_sequencer.sv
// Directed bench for buffer_owner_sequencer; output vector is
// {SLV_GNT, MST_GNT, MST_PREEMPT, BUSY, DBOE_n, ABOE_n, MAOE_n, D2Z_n, Z2D_n}.
module tb_buffer_owner_sequencer;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic SLV_REQ = 1'b0, SLV_READ = 1'b0, SLV_DONE = 1'b0;
  logic MST_REQ = 1'b0, MST_READ = 1'b0, MST_DONE = 1'b0;
  logic SLV_GNT, MST_GNT, MST_PREEMPT, DBOE_n, ABOE_n, MAOE_n, D2Z_n, Z2D_n, BUSY;
  logic [8:0] outs;

  int checks = 0;
  int failures = 0;

  localparam logic [8:0] O_IDLE     = 9'b0000_11111;
  localparam logic [8:0] O_SSET_RD  = 9'b0001_10101;
  localparam logic [8:0] O_SON_RD   = 9'b1001_00101;
  localparam logic [8:0] O_SSET_WR  = 9'b0001_10110;
  localparam logic [8:0] O_SON_WR   = 9'b1001_00110;
  localparam logic [8:0] O_MSET_WR  = 9'b0001_11001;
  localparam logic [8:0] O_MON_WR   = 9'b0101_01001;
  localparam logic [8:0] O_MSET_RD  = 9'b0001_11010;
  localparam logic [8:0] O_MON_RD   = 9'b0101_01010;
  localparam logic [8:0] O_MON_PRE  = 9'b0111_01010;

  buffer_owner_sequencer #(.SETUP_CYCLES(1), .TURN_CYCLES(1), .MAX_MST_CYC(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .SLV_REQ(SLV_REQ), .SLV_READ(SLV_READ), .SLV_DONE(SLV_DONE),
    .MST_REQ(MST_REQ), .MST_READ(MST_READ), .MST_DONE(MST_DONE),
    .SLV_GNT(SLV_GNT), .MST_GNT(MST_GNT), .MST_PREEMPT(MST_PREEMPT),
    .DBOE_n(DBOE_n), .ABOE_n(ABOE_n), .MAOE_n(MAOE_n),
    .D2Z_n(D2Z_n), .Z2D_n(Z2D_n), .BUSY(BUSY)
  );

  assign outs = {SLV_GNT, MST_GNT, MST_PREEMPT, BUSY, DBOE_n, ABOE_n, MAOE_n, D2Z_n, Z2D_n};

  always #5 CLK = ~CLK;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(2);
    checks++;
    if (outs !== O_IDLE) begin
      failures++;
      $display("FAIL reset_values got=%b exp=%b", outs, O_IDLE);
    end
    RESET = 1'b0;
    tick(1);
  endtask

  task automatic test_slave_read();
    SLV_REQ = 1'b1; SLV_READ = 1'b1;
    tick(1);                              // edge 0
    tick(1);                              // edge 1
    checks++;
    if (outs !== O_SSET_RD) begin
      failures++;
      $display("FAIL slv_rd_setup got=%b exp=%b", outs, O_SSET_RD);
    end
    tick(1);                              // edge 2
    checks++;
    if (outs !== O_SON_RD) begin
      failures++;
      $display("FAIL slv_rd_grant got=%b exp=%b", outs, O_SON_RD);
    end
    SLV_REQ = 1'b0;
    tick(2);                              // edges 3,4
    SLV_DONE = 1'b1;
    tick(1);                              // edge 5
    SLV_DONE = 1'b0;
    tick(1);                              // edge 6
    checks++;
    if (outs !== O_SSET_RD) begin
      failures++;
      $display("FAIL slv_rd_turn got=%b exp=%b", outs, O_SSET_RD);
    end
    tick(1);                              // edge 7
    checks++;
    if (outs !== O_IDLE) begin
      failures++;
      $display("FAIL slv_rd_idle got=%b exp=%b", outs, O_IDLE);
    end
  endtask

  task automatic test_master_write();
    logic z2d_seen_low;
    z2d_seen_low = 1'b0;
    MST_REQ = 1'b1; MST_READ = 1'b0;
    tick(1);
    z2d_seen_low |= !Z2D_n;
    tick(1);
    z2d_seen_low |= !Z2D_n;
    checks++;
    if (outs !== O_MSET_WR) begin
      failures++;
      $display("FAIL mst_wr_setup got=%b exp=%b", outs, O_MSET_WR);
    end
    tick(1);
    z2d_seen_low |= !Z2D_n;
    checks++;
    if (outs !== O_MON_WR) begin
      failures++;
      $display("FAIL mst_wr_grant got=%b exp=%b", outs, O_MON_WR);
    end
    MST_REQ = 1'b0;
    MST_DONE = 1'b1;
    tick(1);
    MST_DONE = 1'b0;
    z2d_seen_low |= !Z2D_n;
    tick(1);
    z2d_seen_low |= !Z2D_n;
    checks++;
    if (outs !== O_MSET_WR) begin
      failures++;
      $display("FAIL mst_wr_turn got=%b exp=%b", outs, O_MSET_WR);
    end
    tick(1);
    z2d_seen_low |= !Z2D_n;
    checks++;
    if (outs !== O_IDLE) begin
      failures++;
      $display("FAIL mst_wr_idle got=%b exp=%b", outs, O_IDLE);
    end
    checks++;
    if (z2d_seen_low !== 1'b0) begin
      failures++;
      $display("FAIL mst_wr_z2d_low got=%b exp=0", z2d_seen_low);
    end
  endtask

  task automatic test_back_to_back();
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    SLV_REQ = 1'b1; SLV_READ = 1'b0;
    MST_REQ = 1'b1; MST_READ = 1'b1;
    tick(3);
    checks++;
    if (outs !== O_SON_WR) begin
      failures++;
      $display("FAIL rr_slave_first got=%b exp=%b", outs, O_SON_WR);
    end
    SLV_REQ = 1'b0;
    SLV_DONE = 1'b1;
    tick(1);                              // edge j
    SLV_DONE = 1'b0;
    tick(3);                              // edge j+3
    checks++;
    if (outs !== O_MSET_RD) begin
      failures++;
      $display("FAIL rr_mst_setup got=%b exp=%b", outs, O_MSET_RD);
    end
    tick(1);                              // edge j+4
    checks++;
    if (outs !== O_MON_RD) begin
      failures++;
      $display("FAIL rr_mst_grant got=%b exp=%b", outs, O_MON_RD);
    end
    MST_REQ = 1'b0;
    MST_DONE = 1'b1;
    tick(1);
    MST_DONE = 1'b0;
    tick(2);
  endtask

  task automatic test_preempt();
    MST_REQ = 1'b1; MST_READ = 1'b1;
    tick(3);                              // edges 0..2, tenure counting
    SLV_REQ = 1'b1; SLV_READ = 1'b1;
    tick(7);                              // edge 9
    checks++;
    if (outs !== O_MON_RD) begin
      failures++;
      $display("FAIL preempt_early got=%b exp=%b", outs, O_MON_RD);
    end
    tick(8);                              // edge 17: counter was 15 when sampled
    checks++;
    if (MST_PREEMPT !== 1'b0) begin
      failures++;
      $display("FAIL preempt_edge17 got=%b exp=0", MST_PREEMPT);
    end
    tick(1);                              // edge 18: counter 16 sampled
    checks++;
    if (outs !== O_MON_PRE) begin
      failures++;
      $display("FAIL preempt_edge18 got=%b exp=%b", outs, O_MON_PRE);
    end
    tick(1);                              // edge 19
    MST_REQ = 1'b0;
    MST_DONE = 1'b1;
    tick(1);                              // edge 20
    MST_DONE = 1'b0;
    tick(1);                              // edge 21
    checks++;
    if (MST_PREEMPT !== 1'b0 || MST_GNT !== 1'b0) begin
      failures++;
      $display("FAIL preempt_clear got=%b%b exp=00", MST_PREEMPT, MST_GNT);
    end
    tick(3);                              // edge 24
    checks++;
    if (outs !== O_SON_RD) begin
      failures++;
      $display("FAIL preempt_slv_next got=%b exp=%b", outs, O_SON_RD);
    end
    SLV_REQ = 1'b0;
    SLV_DONE = 1'b1;
    tick(1);
    SLV_DONE = 1'b0;
    tick(2);
  endtask

  task automatic test_abort();
    logic gnt_seen;
    gnt_seen = 1'b0;
    SLV_REQ = 1'b1; SLV_READ = 1'b1;
    tick(1);
    SLV_REQ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      gnt_seen |= SLV_GNT;
    end
    checks++;
    if (gnt_seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_gnt got=%b exp=0", gnt_seen);
    end
    checks++;
    if (outs !== O_IDLE) begin
      failures++;
      $display("FAIL abort_idle got=%b exp=%b", outs, O_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    MST_REQ = 1'b1; MST_READ = 1'b0;
    tick(3);
    checks++;
    if (outs !== O_MON_WR) begin
      failures++;
      $display("FAIL mid_mst_on got=%b exp=%b", outs, O_MON_WR);
    end
    MST_REQ = 1'b0;
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    checks++;
    if (outs !== O_IDLE) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=%b", outs, O_IDLE);
    end
    SLV_DONE = 1'b1; MST_DONE = 1'b1;
    tick(1);
    SLV_DONE = 1'b0;
    tick(1);
    MST_DONE = 1'b0;
    tick(2);
    checks++;
    if (outs !== O_IDLE) begin
      failures++;
      $display("FAIL idle_done_ignored got=%b exp=%b", outs, O_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_slave_read();
    test_master_write();
    test_back_to_back();
    test_preempt();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
